// File: rtl/sw_score_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sw_score_fifo
// Purpose  : Single-clock FIFO that buffers the last-column/row score words
//            spilled by the solver between passes. Width, depth and read mode
//            are generic. It provides an occupancy count, registered
//            almost-full/almost-empty flags and sticky overflow/underflow.
// Ports    : clk, rst (sync, active high), sclr (sync clear)
//            data/wrreq            - write side
//            rdreq/q               - read side (pop acknowledge in showahead)
//            empty, full, almost_full, almost_empty, usedw - status
//            overflow, underflow   - sticky error flags, cleared by rst/sclr
// Revision : 1.0 - initial release
// ============================================================================
module sw_score_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int SHOWAHEAD = 0,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclr,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    usedw_nxt;
  logic             clear;
  logic             rd_ok;
  logic             wr_ok;

  assign clear = rst | sclr;
  assign rd_ok = rdreq & ~empty;
  // A write while full only fits if the same cycle frees a slot.
  assign wr_ok = wrreq & (~full | rd_ok);

  always_comb begin
    usedw_nxt = usedw;
    case ({wr_ok, rd_ok})
      2'b10:   usedw_nxt = usedw + C_ONE;
      2'b01:   usedw_nxt = usedw - C_ONE;
      default: usedw_nxt = usedw;
    endcase
  end

  // Pointers, occupancy and flags. Flags decode the next-state count so they
  // line up with usedw in the same cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_THRESH == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      usedw        <= usedw_nxt;
      empty        <= (usedw_nxt == '0);
      full         <= (usedw_nxt == C_DEPTH);
      almost_empty <= (usedw_nxt <= C_AE);
      almost_full  <= (usedw_nxt >= C_AF);
      if (wrreq & full & ~rd_ok) overflow  <= 1'b1;
      if (rdreq & empty)         underflow <= 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_ptr] <= data;
  end

  generate
    if (SHOWAHEAD == 0) begin : g_normal
      logic [WIDTH-1:0] q_r;
      always_ff @(posedge clk) begin
        if (clear)      q_r <= '0;
        else if (rd_ok) q_r <= mem[rd_ptr];
      end
      assign q = q_r;
    end else begin : g_showahead
      // Head word is presented combinationally; forced to zero while empty
      // so the output is deterministic after reset.
      assign q = empty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sw_score_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_score_fifo
// Purpose  : Directed self-checking bench for sw_score_fifo. One instance in
//            normal read mode (16x1024), one in showahead mode (16x16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_score_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // normal-mode instance
  logic        a_rst, a_sclr, a_wr, a_rd;
  logic [15:0] a_data, a_q;
  logic        a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
  logic [10:0] a_usedw;

  // showahead instance
  logic        b_rst, b_sclr, b_wr, b_rd;
  logic [15:0] b_data, b_q;
  logic        b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
  logic [4:0]  b_usedw;

  sw_score_fifo #(.WIDTH(16), .DEPTH(1024), .SHOWAHEAD(0)) u_dut_a (
    .clk(clk), .rst(a_rst), .sclr(a_sclr), .data(a_data), .wrreq(a_wr), .rdreq(a_rd),
    .q(a_q), .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
    .usedw(a_usedw), .overflow(a_ovf), .underflow(a_unf)
  );

  sw_score_fifo #(.WIDTH(16), .DEPTH(16), .SHOWAHEAD(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .sclr(b_sclr), .data(b_data), .wrreq(b_wr), .rdreq(b_rd),
    .q(b_q), .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
    .usedw(b_usedw), .overflow(b_ovf), .underflow(b_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_status(input string tag, input int uw, input logic emp, input logic ful);
    check_val({tag, "_usedw"}, 32'(a_usedw), 32'(uw));
    check_val({tag, "_empty"}, 32'(a_empty), 32'(emp));
    check_val({tag, "_full"},  32'(a_full),  32'(ful));
  endtask

  task automatic b_status(input string tag, input int uw, input logic emp, input logic ful);
    check_val({tag, "_usedw"}, 32'(b_usedw), 32'(uw));
    check_val({tag, "_empty"}, 32'(b_empty), 32'(emp));
    check_val({tag, "_full"},  32'(b_full),  32'(ful));
  endtask

  initial begin
    a_rst = 1'b1; a_sclr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_data = '0;
    b_rst = 1'b1; b_sclr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_data = '0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;

    // ---------------- normal mode: reset state ----------------
    a_status("a_rst", 0, 1'b1, 1'b0);
    check_val("a_rst_q",   32'(a_q),   32'h0);
    check_val("a_rst_ae",  32'(a_ae),  32'h1);
    check_val("a_rst_af",  32'(a_af),  32'h0);
    check_val("a_rst_ovf", 32'(a_ovf), 32'h0);
    check_val("a_rst_unf", 32'(a_unf), 32'h0);

    // ---------------- test 1: two words, read one cycle later ----------------
    a_wr = 1'b1; a_data = 16'hFF00; tick();
    a_data = 16'hF0F0; tick();
    a_status("a_t1_wr", 2, 1'b0, 1'b0);
    a_wr = 1'b0; a_rd = 1'b1; tick();
    check_val("a_t1_q0", 32'(a_q), 32'hFF00);
    tick();
    a_rd = 1'b0;
    check_val("a_t1_q1", 32'(a_q), 32'hF0F0);
    a_status("a_t1_end", 0, 1'b1, 1'b0);
    tick();
    check_val("a_t1_hold", 32'(a_q), 32'hF0F0);

    // ---------------- test 2: fill, overflow, drain ----------------
    a_wr = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a_data = 16'(i); tick();
      if (i == 3)    check_val("a_t2_ae4",  32'(a_ae), 32'h1);
      if (i == 4)    check_val("a_t2_ae5",  32'(a_ae), 32'h0);
      if (i == 1018) check_val("a_t2_af19", 32'(a_af), 32'h0);
      if (i == 1019) check_val("a_t2_af20", 32'(a_af), 32'h1);
    end
    a_status("a_t2_full", 1024, 1'b0, 1'b1);
    check_val("a_t2_ovf0", 32'(a_ovf), 32'h0);
    a_data = 16'hDEAD; tick();
    a_wr = 1'b0;
    check_val("a_t2_ovf1", 32'(a_ovf), 32'h1);
    check_val("a_t2_uw",   32'(a_usedw), 32'd1024);
    a_rd = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      check_val("a_t2_drain", 32'(a_q), 32'(i));
    end
    a_rd = 1'b0;
    a_status("a_t2_end", 0, 1'b1, 1'b0);

    // ---------------- test 4: underflow ----------------
    a_rd = 1'b1; tick();
    a_rd = 1'b0;
    check_val("a_t4_unf",  32'(a_unf), 32'h1);
    check_val("a_t4_qhld", 32'(a_q),   32'h03FF);
    a_status("a_t4_rej", 0, 1'b1, 1'b0);
    a_rd = 1'b1; a_wr = 1'b1; a_data = 16'h1234; tick();
    a_wr = 1'b0;
    check_val("a_t4_uw1", 32'(a_usedw), 32'd1);
    tick();
    a_rd = 1'b0;
    check_val("a_t4_q",   32'(a_q), 32'h1234);
    a_status("a_t4_end", 0, 1'b1, 1'b0);
    check_val("a_t4_ovf_st", 32'(a_ovf), 32'h1);
    a_sclr = 1'b1; tick();
    a_sclr = 1'b0;
    check_val("a_sclr_ovf", 32'(a_ovf), 32'h0);
    check_val("a_sclr_unf", 32'(a_unf), 32'h0);
    check_val("a_sclr_q",   32'(a_q),   32'h0);

    // ---------------- test 3: full, simultaneous wr+rd across wrap ----------------
    a_wr = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a_data = 16'(i + 16'h5000); tick();
    end
    a_rd = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      a_data = 16'(1024 + k + 16'h5000); tick();
      check_val("a_t3_q",  32'(a_q),     32'(16'(k + 16'h5000)));
      check_val("a_t3_uw", 32'(a_usedw), 32'd1024);
    end
    a_wr = 1'b0; a_rd = 1'b0;
    check_val("a_t3_ovf", 32'(a_ovf), 32'h0);
    check_val("a_t3_full", 32'(a_full), 32'h1);

    // ---------------- test 6: reset mid-burst ----------------
    a_sclr = 1'b1; tick(); a_sclr = 1'b0;
    a_wr = 1'b1;
    for (int i = 0; i < 600; i++) begin
      a_data = 16'(i); tick();
    end
    a_rd = 1'b1; tick();                // q becomes 0 (first word)
    a_rd = 1'b0; a_rst = 1'b1; a_data = 16'hBEEF; tick();
    a_rst = 1'b0; a_wr = 1'b0;
    a_status("a_t6_rst", 0, 1'b1, 1'b0);
    check_val("a_t6_q", 32'(a_q), 32'h0);
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = 16'(16'h0700 + i); tick();
    end
    a_wr = 1'b0; a_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("a_t6_rd", 32'(a_q), 32'(16'h0700 + i));
    end
    a_rd = 1'b0;
    a_status("a_t6_end", 0, 1'b1, 1'b0);

    // ---------------- showahead mode ----------------
    b_status("b_rst", 0, 1'b1, 1'b0);
    check_val("b_rst_ae", 32'(b_ae), 32'h1);
    check_val("b_rst_af", 32'(b_af), 32'h0);
    b_wr = 1'b1; b_data = 16'h0001; tick();
    check_val("b_t5_q1", 32'(b_q), 32'h0001);
    check_val("b_t5_emp", 32'(b_empty), 32'h0);
    b_data = 16'h0002; tick();
    b_wr = 1'b0;
    check_val("b_t5_qhold", 32'(b_q), 32'h0001);
    b_rd = 1'b1; tick();
    check_val("b_t5_pop", 32'(b_q), 32'h0002);
    tick();
    b_rd = 1'b0;
    b_status("b_t5_end", 0, 1'b1, 1'b0);

    // fill 16, almost_full at 12, overflow on 17th
    b_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_data = 16'(16'hA000 + i); tick();
      if (i == 10) check_val("b_af11", 32'(b_af), 32'h0);
      if (i == 11) check_val("b_af12", 32'(b_af), 32'h1);
    end
    b_status("b_full", 16, 1'b0, 1'b1);
    b_data = 16'hDEAD; tick();
    b_wr = 1'b0;
    check_val("b_ovf", 32'(b_ovf), 32'h1);
    check_val("b_ovf_q", 32'(b_q), 32'hA000);
    // wr+rd while full across several wraps
    b_wr = 1'b1; b_rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check_val("b_wrap_q", 32'(b_q), 32'(16'hA000 + k));
      b_data = 16'(16'hA000 + 16 + k); tick();
      check_val("b_wrap_uw", 32'(b_usedw), 32'd16);
    end
    b_wr = 1'b0;
    for (int k = 40; k < 56; k++) begin
      check_val("b_drain_q", 32'(b_q), 32'(16'hA000 + k));
      tick();
    end
    b_rd = 1'b0;
    b_status("b_drain_end", 0, 1'b1, 1'b0);

    // underflow with simultaneous write
    b_sclr = 1'b1; tick(); b_sclr = 1'b0;
    check_val("b_sclr_ovf", 32'(b_ovf), 32'h0);
    b_wr = 1'b1; b_rd = 1'b1; b_data = 16'h55AA; tick();
    b_wr = 1'b0; b_rd = 1'b0;
    check_val("b_unf", 32'(b_unf), 32'h1);
    check_val("b_unf_uw", 32'(b_usedw), 32'd1);
    check_val("b_unf_q", 32'(b_q), 32'h55AA);
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    b_status("b_unf_end", 0, 1'b1, 1'b0);
    b_sclr = 1'b1; tick(); b_sclr = 1'b0;
    check_val("b_sclr_unf", 32'(b_unf), 32'h0);

    // reset mid-burst then ordered readback
    b_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b_data = 16'(i); tick();
    end
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    b_wr = 1'b0;
    b_status("b_t6_rst", 0, 1'b1, 1'b0);
    b_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_data = 16'(16'h0B00 + i); tick();
    end
    b_wr = 1'b0; b_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("b_t6_rd", 32'(b_q), 32'(16'h0B00 + i));
      tick();
    end
    b_rd = 1'b0;
    b_status("b_t6_end", 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
